// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with a registered-read memory and a FWFT output stage.
// It also provides occupancy, almost-full/almost-empty flags and a high-water mark.
module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   high_water
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;
  logic [ADDR_WIDTH:0]   hw_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_vld;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_vld;
  logic                  push;
  logic                  pop;
  logic                  rd_en;
  logic [1:0]            occ;

  assign in_ready = !rst && (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = head_vld && out_ready;

  // Output slots already taken or promised; a read may only be issued
  // if its word is guaranteed a slot when it arrives.
  assign occ   = 2'(head_vld) + 2'(skid_vld) + 2'(rd_vld);
  assign rd_en = (wr_ptr != rd_ptr) && (occ <= 2'(pop) + 2'd1);

  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + 1'b1;
    else if (!push && pop)
      count_next = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
    if (rd_en)
      rd_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      hw_q      <= '0;
      rd_vld    <= 1'b0;
      head_vld  <= 1'b0;
      head_data <= '0;
      skid_vld  <= 1'b0;
    end else begin
      count_q <= count_next;
      if (count_next > hw_q)
        hw_q <= count_next;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      rd_vld <= rd_en;
      if (pop) begin
        if (skid_vld) begin
          head_data <= skid_data;
          skid_vld  <= rd_vld;
          if (rd_vld)
            skid_data <= rd_q;
        end else begin
          head_vld <= rd_vld;
          if (rd_vld)
            head_data <= rd_q;
        end
      end else if (rd_vld) begin
        if (!head_vld) begin
          head_vld  <= 1'b1;
          head_data <= rd_q;
        end else begin
          skid_vld  <= 1'b1;
          skid_data <= rd_q;
        end
      end
    end
  end

  assign out_data     = head_data;
  assign out_valid    = head_vld;
  assign count        = count_q;
  assign high_water   = hw_q;
  assign almost_full  = count_q >= afull_thresh;
  assign almost_empty = count_q <= aempty_thresh;

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: directed scenarios plus a random
// phase checked against a queue-based reference model.
module tb_stream_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 0;
  logic          rst;
  logic          flush;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   afull_thresh;
  logic [AW:0]   aempty_thresh;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   high_water;

  stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
    .count(count), .almost_full(almost_full),
    .almost_empty(almost_empty), .high_water(high_water)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int npops = 0;
  int hw_m = 0;
  int stall = 0;
  logic [DW-1:0] q[$];
  logic          hold = 0;
  logic [DW-1:0] hold_data = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected words enter the model when the producer handshake fires.
  always @(negedge clk) begin
    #1;
    if (rst || flush) begin
      q.delete();
      hw_m = 0;
    end else if (in_valid && in_ready) begin
      q.push_back(in_data);
    end
    if (q.size() > hw_m) hw_m = q.size();
  end

  // Monitor: compares DUT state and popped words against the model.
  always @(negedge clk) begin
    chk("count", 32'(count), q.size());
    chk("in_ready", 32'(in_ready), 32'(!rst && q.size() != DEPTH));
    chk("high_water", 32'(high_water), hw_m);
    chk("almost_full", 32'(almost_full), 32'(q.size() >= afull_thresh));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= aempty_thresh));
    if (hold) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(hold_data));
    end
    if (out_valid) chk("valid_has_data", 32'(q.size() != 0), 1);
    if (rst || flush || out_valid || q.size() == 0) stall = 0;
    else stall++;
    if (stall > 2) begin
      chk("fwft_latency", stall, 2);
      stall = 0;
    end
    if (!rst && !flush && out_valid && out_ready) begin
      npops++;
      if (q.size() == 0) chk("pop_empty_model", 1, 0);
      else chk("pop_data", 32'(out_data), 32'(q.pop_front()));
    end
    hold = out_valid && !out_ready && !rst && !flush;
    hold_data = out_data;
  end

  initial begin
    int n0;
    int maxc;
    logic [DW-1:0] d0;
    rst = 1; flush = 0; in_data = 0; in_valid = 0; out_ready = 0;
    afull_thresh = 14; aempty_thresh = 2;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Fill to capacity, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1; in_data = DW'(i);
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 16);
    chk("full_hw", 32'(high_water), 16);
    chk("full_afull", 32'(almost_full), 1);
    n0 = npops;
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (count == 0) break;
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_pops", npops - n0, 16);
    chk("drain_valid", 32'(out_valid), 0);

    // Single word latency.
    in_valid = 1; in_data = 8'hA5;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("lat_n0", 32'(out_valid), 0);
    step();
    @(negedge clk);
    chk("lat_n1", 32'(out_valid), 0);
    step();
    @(negedge clk);
    chk("lat_n2_valid", 32'(out_valid), 1);
    chk("lat_n2_data", 32'(out_data), 32'h A5);
    step();
    @(negedge clk);
    chk("lat_pop_count", 32'(count), 0);

    // Continuous stream of 40 words.
    n0 = npops; maxc = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1; in_data = DW'(i);
      step();
      @(negedge clk);
      if (int'(count) > maxc) maxc = count;
    end
    in_valid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      if (count == 0) break;
    end
    chk("stream_max_count", maxc, 3);
    chk("stream_pops", npops - n0, 40);

    // Simultaneous push and pop at count 5.
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = DW'(8'h50 + i);
      step();
    end
    in_valid = 0;
    step(); step(); step();
    @(negedge clk);
    chk("c5_count", 32'(count), 5);
    in_valid = 1; in_data = 8'h55; out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    chk("c5_push_pop_count", 32'(count), 5);

    // Backpressure toggling at count 8.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = DW'(8'h60 + i);
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("c8_count", 32'(count), 8);
    out_ready = 1;
    step();
    out_ready = 0;
    @(negedge clk);
    d0 = out_data;
    step();
    @(negedge clk);
    chk("bp_hold1", 32'(out_data), 32'(d0));
    step();
    out_ready = 1;
    @(negedge clk);
    chk("bp_hold2", 32'(out_data), 32'(d0));
    step();
    out_ready = 0;
    @(negedge clk);
    chk("bp_count", 32'(count), 6);

    // Flush at count 9 with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = DW'(8'h70 + i);
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("c9_count", 32'(count), 9);
    flush = 1; in_valid = 1; in_data = 8'hEE;
    step();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_hw", 32'(high_water), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    step(); step(); step();
    @(negedge clk);
    chk("flush_word_absent", 32'(out_valid), 0);

    // Same with reset.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_data = DW'(8'h80 + i);
      step();
    end
    in_valid = 0;
    step(); step();
    rst = 1; in_valid = 1; in_data = 8'hDD;
    @(negedge clk);
    chk("rst9_in_ready", 32'(in_ready), 0);
    step();
    rst = 0; in_valid = 0;
    @(negedge clk);
    chk("rst9_count", 32'(count), 0);
    chk("rst9_valid", 32'(out_valid), 0);
    chk("rst9_hw", 32'(high_water), 0);
    chk("rst9_in_ready_after", 32'(in_ready), 1);
    step(); step(); step();
    @(negedge clk);
    chk("rst9_word_absent", 32'(out_valid), 0);

    // Randomized traffic with occasional flush and threshold changes.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      in_valid = ($urandom_range(0, 3) < 3 - bias);
      out_ready = ($urandom_range(0, 3) < 1 + bias);
      in_data = DW'($urandom);
      flush = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 31) == 0) begin
        afull_thresh = (AW+1)'($urandom_range(0, 16));
        aempty_thresh = (AW+1)'($urandom_range(0, 16));
      end
      step();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      @(negedge clk);
      if (count == 0) break;
    end
    chk("final_drain", 32'(count), 0);
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
